// File: rtl/tmds_channel_encoder.sv
// rtl/tmds_channel_encoder.sv - per-channel TMDS encoder (video/control/TERC4/guard), 2-stage pipeline
// Optional disparity monitor ports and check under TMDS_DISP_MON_EN.
module tmds_channel_encoder #(
  parameter int CN = 0
) (
  input  logic              clk_pixel,
  input  logic              reset_n,
  input  logic [2:0]        mode,
  input  logic [7:0]        video_data,
  input  logic [1:0]        control_data,
  input  logic [3:0]        island_data,
  output logic [9:0]        tmds
`ifdef TMDS_DISP_MON_EN
  ,
  output logic signed [4:0] disparity,
  output logic              disp_err
`endif
);

  localparam logic [2:0] MODE_CTRL   = 3'd0;
  localparam logic [2:0] MODE_VIDEO  = 3'd1;
  localparam logic [2:0] MODE_VGUARD = 3'd2;
  localparam logic [2:0] MODE_ISLAND = 3'd3;
  localparam logic [2:0] MODE_DGUARD = 3'd4;

  localparam logic [9:0] CTRL_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_11 = 10'b1010101011;
  localparam logic [9:0] GB_A    = 10'b1011001100;
  localparam logic [9:0] GB_B    = 10'b0100110011;

  function automatic logic [9:0] terc4(input logic [3:0] d);
    logic [9:0] s;
    case (d)
      4'h0: s = 10'b1010011100;
      4'h1: s = 10'b1001100011;
      4'h2: s = 10'b1011100100;
      4'h3: s = 10'b1011100010;
      4'h4: s = 10'b0101110001;
      4'h5: s = 10'b0100011110;
      4'h6: s = 10'b0110001110;
      4'h7: s = 10'b0100111100;
      4'h8: s = 10'b1011001100;
      4'h9: s = 10'b0100111001;
      4'hA: s = 10'b0110011100;
      4'hB: s = 10'b1011000110;
      4'hC: s = 10'b1010001110;
      4'hD: s = 10'b1001110001;
      4'hE: s = 10'b0101100011;
      default: s = 10'b1011000011;
    endcase
    return s;
  endfunction

  logic [3:0] n1d;
  logic       use_xnor;
  logic [8:0] q_m_d;

  // Stage 1: transition-minimising 9-bit word
  always_comb begin
    n1d = 4'd0;
    for (int i = 0; i < 8; i++) n1d = n1d + {3'b000, video_data[i]};
    use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !video_data[0]);
    q_m_d[0] = video_data[0];
    for (int i = 1; i < 8; i++)
      q_m_d[i] = use_xnor ? ~(q_m_d[i-1] ^ video_data[i]) : (q_m_d[i-1] ^ video_data[i]);
    q_m_d[8] = ~use_xnor;
  end

  logic [8:0] s1_q_m;
  logic [2:0] s1_mode;
  logic [1:0] s1_ctrl;
  logic [3:0] s1_island;

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      s1_q_m    <= '0;
      s1_mode   <= MODE_CTRL;
      s1_ctrl   <= 2'b00;
      s1_island <= '0;
    end else begin
      s1_q_m    <= q_m_d;
      s1_mode   <= mode;
      s1_ctrl   <= control_data;
      s1_island <= island_data;
    end
  end

  logic [3:0]        n1q;
  logic signed [4:0] bal;
  logic signed [4:0] cnt;
  logic signed [4:0] cnt_next;
  logic [9:0]        sym_next;
  logic              q8;
  logic [7:0]        q;

  assign q8 = s1_q_m[8];
  assign q  = s1_q_m[7:0];

  // bal = N1 - N0 of q_m[7:0]
  always_comb begin
    n1q = 4'd0;
    for (int i = 0; i < 8; i++) n1q = n1q + {3'b000, q[i]};
    bal = $signed({n1q, 1'b0}) - 5'sd8;
  end

  always_comb begin
    sym_next = CTRL_00;
    cnt_next = 5'sd0;
    case (s1_mode)
      MODE_VIDEO: begin
        if (cnt == 5'sd0 || bal == 5'sd0) begin
          sym_next = {~q8, q8, (q8 ? q : ~q)};
          cnt_next = q8 ? (cnt + bal) : (cnt - bal);
        end else if ((cnt > 5'sd0 && bal > 5'sd0) || (cnt < 5'sd0 && bal < 5'sd0)) begin
          sym_next = {1'b1, q8, ~q};
          cnt_next = cnt - bal + (q8 ? 5'sd2 : 5'sd0);
        end else begin
          sym_next = {1'b0, q8, q};
          cnt_next = cnt + bal - (q8 ? 5'sd0 : 5'sd2);
        end
      end
      MODE_VGUARD: sym_next = (CN == 1) ? GB_B : GB_A;
      MODE_ISLAND: sym_next = terc4(s1_island);
      MODE_DGUARD: sym_next = (CN == 0) ? terc4(s1_island) : GB_B;
      default: begin
        case (s1_ctrl)
          2'b00:   sym_next = CTRL_00;
          2'b01:   sym_next = CTRL_01;
          2'b10:   sym_next = CTRL_10;
          default: sym_next = CTRL_11;
        endcase
      end
    endcase
  end

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      tmds <= CTRL_00;
      cnt  <= 5'sd0;
    end else begin
      tmds <= sym_next;
      cnt  <= cnt_next;
    end
  end

`ifdef TMDS_DISP_MON_EN
  logic out_of_range;
  assign out_of_range = (cnt_next > 5'sd10) || (cnt_next < -5'sd10);
  assign disparity    = cnt;

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n)          disp_err <= 1'b0;
    else if (out_of_range) disp_err <= 1'b1;
  end

`ifndef SYNTHESIS
  always @(posedge clk_pixel) begin
    if (reset_n) assert (!out_of_range) else $error("tmds disparity out of range: %0d", cnt_next);
  end
`endif
`endif

endmodule
